spike_rate_encoder: RTL

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/spike_rate_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spike_rate_encoder.sv
// Rate encoder: per-channel LFSR samples compared to a latched intensity
// give one Bernoulli spike per time step over a T_STEPS window.
// Ports: clk, reset (sync, active-high); pix_valid/pix_ready/pix_data
// accept an N_CH x WIDTH intensity vector; step_en is the time-step tick;
// spike_out/spike_valid carry the registered spikes; window_done pulses
// for one cycle at window end; busy flags a window in progress.
// Option: define ENCODER_REFRACTORY_EN to block a spike on the step
// following a spike on the same channel.
module spike_rate_encoder #(
  parameter int          N_CH      = 2,
  parameter int          WIDTH     = 8,
  parameter int          T_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [N_CH*WIDTH-1:0] pix_data,
  input  logic                  step_en,
  output logic [N_CH-1:0]       spike_out,
  output logic                  spike_valid,
  output logic                  window_done,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] LAST = 16'(T_STEPS - 1);

  logic [1:0]            state;
  logic [15:0]           cnt;
  logic [N_CH*WIDTH-1:0] inten;
  logic [15:0]           lfsr [N_CH];
  logic [N_CH-1:0]       hit;
  logic [N_CH-1:0]       fire;
  logic                  step;

  // Seed: forced-odd base rotated left by channel index, never zero.
  function automatic logic [15:0] seed_of(input int i);
    logic [15:0] b;
    logic [31:0] d;
    b = {LFSR_SEED[15:1], 1'b1};
    d = {b, b} << (i % 16);
    return d[31:16];
  endfunction

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_nx(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  assign step        = (state == S_RUN) && step_en;
  assign pix_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign window_done = (state == S_DONE);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (lfsr[i][WIDTH-1:0] < inten[i*WIDTH +: WIDTH])
             || (&inten[i*WIDTH +: WIDTH]);
    end
  end

`ifdef ENCODER_REFRACTORY_EN
  logic [N_CH-1:0] refr;

  assign fire = hit & ~refr;

  always_ff @(posedge clk) begin
    if (reset) begin
      refr <= '0;
    end else if (state == S_IDLE && pix_valid) begin
      refr <= '0;
    end else if (step) begin
      refr <= fire;
    end
  end
`else
  assign fire = hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      inten       <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        lfsr[i] <= seed_of(i);
      end
    end else begin
      spike_valid <= step;
      case (state)
        S_IDLE: begin
          if (pix_valid) begin
            inten <= pix_data;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (step_en) begin
            for (int i = 0; i < N_CH; i++) begin
              lfsr[i] <= lfsr_nx(lfsr[i]);
            end
            spike_out <= fire;
            cnt       <= cnt + 16'd1;
            if (cnt == LAST) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          spike_out <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
